// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, decode handshake and imem write port of the fetch queue
interface fetch_queue_if #(
    parameter int XLEN       = 32,
    parameter int IMEM_BYTES = 256,
    parameter int FIFO_DEPTH = 4
);
    logic                          redirect;
    logic [XLEN-1:0]               redirect_pc;
    logic                          out_valid;
    logic                          out_ready;
    logic [31:0]                   out_instr;
    logic [XLEN-1:0]               out_pc;
    logic [XLEN-1:0]               out_pc_plus4;
    logic                          out_fault;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          imem_we;
    logic [$clog2(IMEM_BYTES)-1:0] imem_waddr;
    logic [31:0]                   imem_wdata;
    modport master (
        output redirect, redirect_pc, out_ready, imem_we, imem_waddr, imem_wdata,
        input  out_valid, out_instr, out_pc, out_pc_plus4, out_fault, fifo_count
    );
    modport slave (
        input  redirect, redirect_pc, out_ready, imem_we, imem_waddr, imem_wdata,
        output out_valid, out_instr, out_pc, out_pc_plus4, out_fault, fifo_count
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch from internal imem into a prefetch FIFO feeding decode
module fetch_queue_unit #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_BYTES = 256,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input logic clk,
    input logic rst_n,
    fetch_queue_if.slave bus
);
    localparam int AW = $clog2(IMEM_BYTES);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0]     mem     [IMEM_BYTES/4];
    logic [XLEN-1:0] q_pc    [FIFO_DEPTH];
    logic [31:0]     q_instr [FIFO_DEPTH];
    logic            q_fault [FIFO_DEPTH];
    logic [XLEN-1:0] fetch_pc;
    logic            halted;
    logic [PW-1:0]   head, tail;
    logic [PW:0]     count;
    logic            fault, push, pop, unused_waddr_lo;
    logic [31:0]     word;

    assign unused_waddr_lo = ^bus.imem_waddr[1:0];
    assign fault = (fetch_pc[1:0] != 2'b00) || (fetch_pc > XLEN'(IMEM_BYTES - 4));
    assign word  = fault ? 32'h0 : mem[fetch_pc[AW-1:2]];
    assign pop   = bus.out_valid && bus.out_ready;
    assign push  = !halted && !bus.redirect && (count < (PW+1)'(FIFO_DEPTH) || pop);

    // reads see the pre-write word when the same word is written this cycle
    always_ff @(posedge clk) begin
        if (bus.imem_we)
            mem[bus.imem_waddr[AW-1:2]] <= bus.imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= fetch_pc;
            q_instr[tail] <= word;
            q_fault[tail] <= fault;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            halted   <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
                if (fault)
                    halted <= 1'b1;
                else
                    fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (pop)
                head <= head + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_comb begin
        bus.out_valid    = count != '0;
        bus.out_pc       = bus.out_valid ? q_pc[head] : '0;
        bus.out_instr    = bus.out_valid ? q_instr[head] : 32'h0;
        bus.out_fault    = bus.out_valid ? q_fault[head] : 1'b0;
        bus.out_pc_plus4 = bus.out_pc + XLEN'(4);
        bus.fifo_count   = count;
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: table-driven directed checks of fetch_queue_unit plus imem write-collision sequence
module tb_fetch_queue_unit;
    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
        logic [2:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];

    fetch_queue_if #(.XLEN(32), .IMEM_BYTES(256), .FIFO_DEPTH(4)) bus ();
    fetch_queue_unit #(.XLEN(32), .IMEM_BYTES(256), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(int k);
        return 32'h11111111 * (k + 1);
    endfunction

    task automatic add(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc,
                       input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic f, input int c);
        vec_t x;
        x.rst_n = r; x.ready = rdy; x.redir = rd; x.rpc = rpc;
        x.valid = v; x.pc = pc; x.instr = ins; x.fault = f; x.cnt = 3'(c);
        vecs.push_back(x);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int idx, input vec_t e);
        chk({tag, ".valid"}, idx, 32'(bus.out_valid), 32'(e.valid));
        chk({tag, ".count"}, idx, 32'(bus.fifo_count), 32'(e.cnt));
        chk({tag, ".pc"}, idx, bus.out_pc, e.pc);
        chk({tag, ".pc_plus4"}, idx, bus.out_pc_plus4, e.pc + 32'd4);
        chk({tag, ".instr"}, idx, bus.out_instr, e.instr);
        chk({tag, ".fault"}, idx, 32'(bus.out_fault), 32'(e.fault));
    endtask

    initial begin
        vec_t e;
        rst_n = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            bus.imem_we = 1'b1; bus.imem_waddr = 8'(4 * k); bus.imem_wdata = w(k);
            step();
        end
        bus.imem_waddr = 8'hFC; bus.imem_wdata = 32'hCAFEF00D;
        step();
        bus.imem_we = 1'b0;

        // streaming with out_ready held high
        add(0,0,0,0, 0,0,0,0,0);
        for (int i = 0; i < 5; i++) add(1,1,0,0, 1,32'(4*i),w(i),0,1);
        // backpressure then release
        add(0,0,0,0, 0,0,0,0,0);
        for (int i = 0; i < 10; i++) add(1,0,0,0, 1,0,w(0),0, i < 3 ? i + 1 : 4);
        for (int i = 1; i < 8; i++) add(1,1,0,0, 1,32'(4*i),w(i),0,4);
        // full queue flushed by redirect to 4
        add(0,0,0,0, 0,0,0,0,0);
        add(1,1,0,0, 1,0,w(0),0,1);
        add(1,1,0,0, 1,4,w(1),0,1);
        add(1,1,0,0, 1,8,w(2),0,1);
        add(1,0,0,0, 1,8,w(2),0,2);
        add(1,0,0,0, 1,8,w(2),0,3);
        add(1,0,0,0, 1,8,w(2),0,4);
        add(1,1,1,4, 0,0,0,0,0);
        add(1,1,0,0, 1,4,w(1),0,1);
        add(1,1,0,0, 1,8,w(2),0,1);
        // last valid word then out-of-range fault
        add(1,0,1,32'hFC, 0,0,0,0,0);
        add(1,0,0,0, 1,32'hFC,32'hCAFEF00D,0,1);
        add(1,0,0,0, 1,32'hFC,32'hCAFEF00D,0,2);
        add(1,0,0,0, 1,32'hFC,32'hCAFEF00D,0,2);
        add(1,1,0,0, 1,32'h100,0,1,1);
        add(1,0,0,0, 1,32'h100,0,1,1);
        add(1,1,0,0, 0,0,0,0,0);
        add(1,1,0,0, 0,0,0,0,0);
        add(1,1,1,0, 0,0,0,0,0);
        add(1,1,0,0, 1,0,w(0),0,1);
        // misaligned redirect, then reset mid-stream
        add(1,0,1,6, 0,0,0,0,0);
        add(1,0,0,0, 1,6,0,1,1);
        add(1,0,0,0, 1,6,0,1,1);
        add(0,0,0,0, 0,0,0,0,0);
        add(1,1,0,0, 1,0,w(0),0,1);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            bus.out_ready = vecs[i].ready;
            bus.redirect = vecs[i].redir;
            bus.redirect_pc = vecs[i].rpc;
            step();
            check_out("row", i, vecs[i]);
        end
        bus.redirect = 1'b0;

        // imem write colliding with the fetch of the same word
        rst_n = 1'b0; bus.out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        bus.imem_we = 1'b1; bus.imem_waddr = 8'd8; bus.imem_wdata = 32'hDEADBEEF;
        step();
        bus.imem_we = 1'b0;
        chk("wr.count", 0, 32'(bus.fifo_count), 32'd3);
        bus.out_ready = 1'b1;
        step();
        step();
        e = '{1,1,0,0, 1,32'd8,w(2),0,3};
        check_out("wr.old", 0, e);
        bus.redirect = 1'b1; bus.redirect_pc = 32'd8;
        step();
        bus.redirect = 1'b0;
        e = '{1,1,0,0, 0,0,0,0,0};
        check_out("wr.flush", 0, e);
        step();
        e = '{1,1,0,0, 1,32'd8,32'hDEADBEEF,0,1};
        check_out("wr.new", 0, e);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
